// File: rtl/dfd_cla_pkg.sv
// dfd_cla_pkg: shared types and constants for the CLA node graph.
package dfd_cla_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } ClaSeqState_e;
  localparam int CLA_SEQ_STOP_ACTION = 1;
  localparam int CLA_STATUS_NODE_W = 8;
  localparam int CLA_STATUS_CNT_W = 16;
  // Fixed-width snapshot for the CSR read path, independent of instance sizing.
  typedef struct packed {
    ClaSeqState_e                  state;
    logic [CLA_STATUS_NODE_W-1:0]  current_node;
    logic [CLA_STATUS_CNT_W-1:0]   transition_count;
  } ClaSeqStatus_s;
endpackage

// File: rtl/dfd_cla_eap_prio_arb.sv
// dfd_cla_eap_prio_arb: fixed-priority find-first-set, lowest index wins.
module dfd_cla_eap_prio_arb #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (i_req[i]) o_idx = IDX_W'(i);
  end
endmodule

// File: rtl/dfd_cla_node_sequencer.sv
// dfd_cla_node_sequencer: owns current node and the IDLE/RUN/HALT control,
// committing one arbitrated EAP transition per cycle while running.
module dfd_cla_node_sequencer
  import dfd_cla_pkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int EAPS_PER_NODE = 4,
  parameter int NUM_ACTIONS = 16,
  parameter int NODE_ID_W = $clog2(NUM_NODES),
  parameter int STOP_ACTION = CLA_SEQ_STOP_ACTION,
  parameter int CNT_W = 16,
  localparam int NUM_EAPS = NUM_NODES * EAPS_PER_NODE,
  localparam int EAP_W = $clog2(EAPS_PER_NODE)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              i_cla_enable,
  input  logic                              i_sw_start,
  input  logic                              i_sw_stop,
  input  logic                              i_sw_restart,
  input  logic [NODE_ID_W-1:0]              i_start_node,
  input  logic [NUM_EAPS-1:0]               i_eap_fire,
  input  logic [NUM_EAPS*NODE_ID_W-1:0]     i_eap_dest_node,
  input  logic [NUM_EAPS*NUM_ACTIONS-1:0]   i_eap_actions,
  output logic                              o_enable_eap,
  output logic [NODE_ID_W-1:0]              o_current_node_id,
  output logic [NUM_ACTIONS-1:0]            o_action_bus,
  output logic                              o_node_transition,
  output logic [EAP_W-1:0]                  o_winner_eap,
  output logic [1:0]                        o_seq_state,
  output logic [CNT_W-1:0]                  o_transition_count
);
  ClaSeqState_e           r_state, w_state_nxt;
  logic [NODE_ID_W-1:0]   r_node, w_node_nxt, w_dest;
  logic [NUM_ACTIONS-1:0] r_act, w_act_nxt, w_act;
  logic                   r_trans, w_trans_nxt, w_valid;
  logic [EAP_W-1:0]       r_win, w_win_nxt, w_idx;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [EAPS_PER_NODE-1:0] w_cand;
  int                     w_gidx;

  assign w_cand = i_eap_fire[int'(r_node)*EAPS_PER_NODE +: EAPS_PER_NODE];

  dfd_cla_eap_prio_arb #(.N(EAPS_PER_NODE)) u_arb (
    .i_req  (w_cand),
    .o_valid(w_valid),
    .o_idx  (w_idx)
  );

  assign w_gidx = int'(r_node) * EAPS_PER_NODE + int'(w_idx);
  assign w_dest = i_eap_dest_node[w_gidx*NODE_ID_W +: NODE_ID_W];
  assign w_act  = i_eap_actions[w_gidx*NUM_ACTIONS +: NUM_ACTIONS];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_node  <= '0;
      r_act   <= '0;
      r_trans <= 1'b0;
      r_win   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_node  <= w_node_nxt;
      r_act   <= w_act_nxt;
      r_trans <= w_trans_nxt;
      r_win   <= w_win_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Disable beats every other request and discards any same-cycle winner.
  always_comb begin
    w_state_nxt = r_state;
    w_node_nxt  = r_node;
    w_act_nxt   = '0;
    w_trans_nxt = 1'b0;
    w_win_nxt   = r_win;
    w_cnt_nxt   = r_cnt;
    if (!i_cla_enable) begin
      w_state_nxt = IDLE;
      w_node_nxt  = '0;
    end else if (r_state == IDLE) begin
      if (i_sw_start) begin
        w_state_nxt = RUN;
        w_node_nxt  = i_start_node;
        w_cnt_nxt   = '0;
      end
    end else if (r_state == RUN) begin
      if (w_valid) begin
        w_node_nxt  = w_dest;
        w_act_nxt   = w_act;
        w_trans_nxt = 1'b1;
        w_win_nxt   = w_idx;
        w_cnt_nxt   = &r_cnt ? r_cnt : r_cnt + 1'b1;
      end
      if (i_sw_stop || (w_valid && w_act[STOP_ACTION])) w_state_nxt = HALT;
    end else begin
      w_state_nxt = i_sw_restart ? IDLE : (i_sw_start ? RUN : r_state);
    end
  end

  assign o_enable_eap       = (r_state == RUN);
  assign o_current_node_id  = r_node;
  assign o_action_bus       = r_act;
  assign o_node_transition  = r_trans;
  assign o_winner_eap       = r_win;
  assign o_seq_state        = r_state;
  assign o_transition_count = r_cnt;
endmodule
